// File: rtl/pk_pkg.sv
// Pass-Keeper shared definitions.
// Holds the datapath width, round count, vault depth, the controller state
// encoding and the vault entry layout used by hw_wrapper and pk_cipher_round.
package pk_pkg;

  localparam int unsigned PK_W      = 128;
  localparam int unsigned PK_ROUNDS = 8;
  localparam int unsigned PK_DEPTH  = 16;
  localparam int unsigned PK_RND_W  = 3;  // round counter width
  localparam int unsigned PK_IDX_W  = 4;  // vault index width
  localparam int unsigned PK_WP_W   = 5;  // write pointer counts 0..PK_DEPTH

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } pk_state_e;

  typedef struct packed {
    logic            valid;
    logic [PK_W-1:0] acc;
    logic [PK_W-1:0] cipher;
  } pk_entry_t;

endpackage

// File: rtl/pk_cipher_round.sv
// One combinational ARX round.
//   s_i     : round input state S_i
//   key_i   : cipher key K
//   round_i : round index i (0..7)
//   s_o     : S_{i+1} = rotl((S_i + rk_i), 7) ^ rk_i,
//             with rk_i = rotl(K, 16*i) ^ i
module pk_cipher_round
  import pk_pkg::*;
(
  input  logic [PK_W-1:0]     s_i,
  input  logic [PK_W-1:0]     key_i,
  input  logic [PK_RND_W-1:0] round_i,
  output logic [PK_W-1:0]     s_o
);

  logic [7:0]      sh;
  logic [PK_W-1:0] key_rot;
  logic [PK_W-1:0] rk;
  logic [PK_W-1:0] sum;

  always_comb begin
    sh      = {1'b0, round_i, 4'b0000};
    // A shift by the full width yields zero, so round 0 needs no special case.
    key_rot = (key_i << sh) | (key_i >> (8'(PK_W) - sh));
    rk      = key_rot ^ PK_W'(round_i);
    sum     = s_i + rk;
    s_o     = {sum[PK_W-8:0], sum[PK_W-1:PK_W-7]} ^ rk;
  end

endmodule

// File: rtl/hw_wrapper.sv
// Pass-Keeper core: encrypts a password with an 8-round ARX cipher, then
// looks the account up in a 16-entry vault (hit returns stored ciphertext,
// miss stores and returns the fresh one if there is room).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   go                : start request, honoured only in IDLE
//   master_key        : cipher key, captured with go
//   account           : account identifier, captured with go
//   password          : plaintext, captured with go
//   max_address       : highest usable vault index, captured with go
//   done              : one-cycle completion pulse
//   password_enc      : registered result, held until the next completion
// Build option: PASSKEEPER_ACCOUNT_TWEAK_EN mixes the account into the key.
module hw_wrapper
  import pk_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [PK_W-1:0]     master_key,
  input  logic [PK_W-1:0]     account,
  input  logic [PK_W-1:0]     password,
  input  logic [PK_IDX_W-1:0] max_address,
  output logic                done,
  output logic [PK_W-1:0]     password_enc
);

  pk_state_e             state_q, state_d;
  logic [PK_RND_W-1:0]   rnd_q, rnd_d;
  logic [PK_W-1:0]       s_q, s_d;
  logic [PK_W-1:0]       key_q, key_d;
  logic [PK_W-1:0]       acc_q, acc_d;
  logic [PK_IDX_W-1:0]   max_q, max_d;
  logic [PK_WP_W-1:0]    wp_q, wp_d;
  logic                  done_q, done_d;
  logic [PK_W-1:0]       enc_q, enc_d;
  pk_entry_t             vault_q [PK_DEPTH];
  pk_entry_t             vault_d [PK_DEPTH];

  logic [PK_W-1:0]       key_in;
  logic [PK_W-1:0]       round_out;
  logic                  hit;
  logic [PK_IDX_W-1:0]   hit_idx;

`ifdef PASSKEEPER_ACCOUNT_TWEAK_EN
  assign key_in = master_key ^ account;
`else
  assign key_in = master_key;
`endif

  pk_cipher_round u_round (
    .s_i     (s_q),
    .key_i   (key_q),
    .round_i (rnd_q),
    .s_o     (round_out)
  );

  // Parallel compare; scanning downwards leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int j = PK_DEPTH - 1; j >= 0; j--) begin
      if (PK_IDX_W'(j) <= max_q && vault_q[j].valid && vault_q[j].acc == acc_q) begin
        hit     = 1'b1;
        hit_idx = PK_IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    key_d   = key_q;
    acc_d   = acc_q;
    max_d   = max_q;
    wp_d    = wp_q;
    done_d  = 1'b0;
    enc_d   = enc_q;
    vault_d = vault_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          key_d   = key_in;
          acc_d   = account;
          max_d   = max_address;
          s_d     = password ^ key_in;
          rnd_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = round_out;
        rnd_d = rnd_q + 1'b1;
        if (rnd_q == PK_RND_W'(PK_ROUNDS - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (hit) begin
          enc_d = vault_q[hit_idx].cipher;
        end else begin
          enc_d = s_q;
          // Full vault (wp beyond max_address) returns the ciphertext unstored.
          if (wp_q <= {1'b0, max_q}) begin
            vault_d[wp_q[PK_IDX_W-1:0]] = '{valid: 1'b1, acc: acc_q, cipher: s_q};
            wp_d = wp_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      s_q     <= '0;
      key_q   <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      wp_q    <= '0;
      done_q  <= 1'b0;
      enc_q   <= '0;
      for (int j = 0; j < PK_DEPTH; j++) begin
        vault_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      key_q   <= key_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      wp_q    <= wp_d;
      done_q  <= done_d;
      enc_q   <= enc_d;
      for (int j = 0; j < PK_DEPTH; j++) begin
        vault_q[j] <= vault_d[j];
      end
    end
  end

  assign done         = done_q;
  assign password_enc = enc_q;

endmodule

// File: tb/tb_hw_wrapper.sv
// Directed self-checking bench for hw_wrapper (default build).
module tb_hw_wrapper;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go = 1'b0;
  logic [127:0] master_key = '0;
  logic [127:0] account = '0;
  logic [127:0] password = '0;
  logic [3:0]   max_address = '0;
  logic         done;
  logic [127:0] password_enc;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [127:0] KEY_A = 128'hf256847daea39da5d870adf569712360;
  localparam logic [127:0] PW_A  = 128'hf256847daaa39da5d870adf569712360;
  localparam logic [127:0] PW_B  = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] ACC_X = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
  localparam logic [127:0] ACC_Y = 128'hbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbbb;

  hw_wrapper dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .master_key   (master_key),
    .account      (account),
    .password     (password),
    .max_address  (max_address),
    .done         (done),
    .password_enc (password_enc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference cipher written straight from the round equations.
  function automatic logic [127:0] model(input logic [127:0] key, input logic [127:0] pw);
    logic [127:0] s, rk, t;
    s = pw ^ key;
    for (int i = 0; i < 8; i++) begin
      rk = key;
      for (int r = 0; r < i; r++) rk = {rk[111:0], rk[127:112]};
      rk = rk ^ 128'(i);
      t  = s + rk;
      s  = {t[120:0], t[127:121]} ^ rk;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after done has dropped.
  task automatic run_op(input string tag, input logic [127:0] key, input logic [127:0] acc,
                        input logic [127:0] pw, input logic [3:0] maxa,
                        output logic [127:0] res);
    int k;
    master_key  = key;
    account     = acc;
    password    = pw;
    max_address = maxa;
    go          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go       = 1'b0;
    // Scramble inputs: the operation in flight must not see them.
    master_key = ~key;
    account    = ~acc;
    password   = ~pw;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 128'(k), 128'd9);
    res = password_enc;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_width"}, 128'(done), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] res;
    int cnt, first, last;

    // Reset state and quiet idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", 128'(done), 128'd0);
    check("rst_enc", password_enc, 128'd0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("idle_no_done", 128'(cnt), 128'd0);

    // Zero vector
    run_op("zero", '0, '0, '0, 4'd0, res);
    check("zero_enc", res, 128'h20C287122C687);
    check("zero_wp", 128'(dut.wp_q), 128'd1);

    // Full vault with max_address = 0
    do_reset();
    run_op("fullA", KEY_A, '0, PW_A, 4'd0, res);
    check("fullA_enc", res, model(KEY_A, PW_A));
    run_op("fullB", KEY_A, ACC_X, PW_A, 4'd0, res);
    check("fullB_enc", res, model(KEY_A, PW_A));
    check("fullB_wp", 128'(dut.wp_q), 128'd1);
    // Had B been stored, this would hit and return the older ciphertext.
    run_op("fullB2", KEY_A, ACC_X, PW_B, 4'd0, res);
    check("fullB2_enc", res, model(KEY_A, PW_B));

    // Hit returns the ciphertext stored by the first op
    run_op("hit", KEY_A, '0, PW_B, 4'd0, res);
    check("hit_enc", res, model(KEY_A, PW_A));
    check("hit_wp", 128'(dut.wp_q), 128'd1);

    // Widen the window: ACC_X lands in slot 1
    run_op("wide", KEY_A, ACC_X, PW_B, 4'd15, res);
    check("wide_enc", res, model(KEY_A, PW_B));
    check("wide_wp", 128'(dut.wp_q), 128'd2);
    run_op("wide_hit", KEY_A, ACC_X, PW_A, 4'd15, res);
    check("wide_hit_enc", res, model(KEY_A, PW_B));
    // Slot 1 lies beyond max_address = 0, so it must not hit
    run_op("narrow", KEY_A, ACC_X, PW_A, 4'd0, res);
    check("narrow_enc", res, model(KEY_A, PW_A));

    // Busy: go held high, one done per 10-cycle window
    master_key  = KEY_A;
    account     = '0;
    password    = PW_B;
    max_address = 4'd0;
    go          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt = 0; first = -1; last = -1;
    for (int k = 1; k <= 29; k++) begin
      if (k == 29) go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check("busy_count", 128'(cnt), 128'd3);
    check("busy_first", 128'(first), 128'd9);
    check("busy_last", 128'(last), 128'd29);
    check("busy_enc", password_enc, model(KEY_A, PW_A));
    repeat (3) @(negedge clk);

    // Reset during round 4
    master_key  = KEY_A;
    account     = ACC_Y;
    password    = PW_A;
    max_address = 4'd15;
    go          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", 128'(cnt), 128'd0);
    check("abort_wp", 128'(dut.wp_q), 128'd0);
    check("abort_enc", password_enc, 128'd0);
    run_op("after_abort", KEY_A, '0, PW_B, 4'd15, res);
    check("after_abort_enc", res, model(KEY_A, PW_B));
    check("after_abort_wp", 128'(dut.wp_q), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
